// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared arbiter state encoding, owner encoding and tag type
//                for the I/D-cache main-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } owner_tag_t;

    // On a simultaneous miss the cache that was not served last wins.
    function automatic logic tie_winner(input logic last_grant);
        return (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
    endfunction

endpackage

`default_nettype wire

// File: rtl/owner_tag_pipe.sv
// ============================================================================
//  Module      : owner_tag_pipe
//  Description : Fixed-depth shift register tracking which cache owns each
//                outstanding memory read, aligned to the memory read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module owner_tag_pipe
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  owner_tag_t push,
    output owner_tag_t tail
);

    owner_tag_t r_stage [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) r_stage[0] <= '0;
                    else     r_stage[0] <= push;
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) r_stage[gi] <= '0;
                    else     r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign tail = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates main memory between the I-cache and D-cache fill
//                FSMs and write-through stores; routes read returns to owner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic        d_miss,
    input  logic        i_busy,
    input  logic        d_busy,
    input  logic        i_mem_en,
    input  logic        d_mem_en,
    input  logic [15:0] i_addr,
    input  logic [15:0] d_addr,
    input  logic        d_wr_en,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic        memory_data_valid,
    output logic        i_proceed,
    output logic        d_proceed,
    output logic        d_wr_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic        route_err
);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_started;
    logic        r_last_grant;
    logic        r_route_err;

    logic        w_granted;
    logic        w_grant_owner;
    logic        w_sel_busy;
    logic        w_sel_miss;
    logic        w_release;
    owner_tag_t  w_push;
    owner_tag_t  w_tail;

    assign w_granted     = (r_state == GRANT_I) || (r_state == GRANT_D);
    assign w_grant_owner = (r_state == GRANT_D) ? OWNER_D : OWNER_I;
    assign w_sel_busy    = (r_state == GRANT_D) ? d_busy : i_busy;
    assign w_sel_miss    = (r_state == GRANT_D) ? d_miss : i_miss;

    // Before the FSM goes busy a dropped miss releases; afterwards only busy falling does.
    assign w_release = (r_started & ~w_sel_busy) | (~r_started & ~w_sel_miss);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_miss && d_miss)
                    w_next_state = (tie_winner(r_last_grant) == OWNER_D) ? GRANT_D : GRANT_I;
                else if (d_miss)
                    w_next_state = GRANT_D;
                else if (i_miss)
                    w_next_state = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                if (w_release) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_started    <= 1'b0;
            r_last_grant <= OWNER_I;
            r_route_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_granted && w_release) begin
                r_started    <= 1'b0;
                r_last_grant <= w_grant_owner;
            end else if (w_granted && w_sel_busy) begin
                r_started <= 1'b1;
            end
            if (memory_data_valid && !w_tail.valid)
                r_route_err <= 1'b1;
        end
    end

    assign i_proceed = (r_state == GRANT_I);
    assign d_proceed = (r_state == GRANT_D);
    assign route_err = r_route_err;

    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'h0000;
        mem_data_in = 16'h0000;
        d_wr_stall  = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_wr_en) begin
                    if (i_miss || d_miss) begin
                        d_wr_stall = 1'b1;
                    end else begin
                        mem_en      = 1'b1;
                        mem_wr      = 1'b1;
                        mem_addr    = d_wr_addr;
                        mem_data_in = d_wr_data;
                    end
                end
            end
            GRANT_I: begin
                mem_en     = i_mem_en;
                mem_addr   = i_addr;
                d_wr_stall = d_wr_en;
            end
            GRANT_D: begin
                mem_en     = d_mem_en;
                mem_addr   = d_addr;
                d_wr_stall = d_wr_en;
            end
            default: begin
                d_wr_stall = d_wr_en;
            end
        endcase
    end

    assign w_push.valid = mem_en & ~mem_wr;
    assign w_push.owner = w_grant_owner;

    owner_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_owner_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .tail (w_tail)
    );

    assign i_data_valid = memory_data_valid & w_tail.valid & (w_tail.owner == OWNER_I);
    assign d_data_valid = memory_data_valid & w_tail.valid & (w_tail.owner == OWNER_D);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a cycle-level
//                reference model and directed fill/store/reset scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int MEM_LATENCY = 4;
    localparam int LOG_N       = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, i_busy = 1'b0, d_busy = 1'b0;
    logic        i_mem_en = 1'b0, d_mem_en = 1'b0;
    logic [15:0] i_addr = 16'h0, d_addr = 16'h0;
    logic        d_wr_en = 1'b0;
    logic [15:0] d_wr_addr = 16'h0, d_wr_data = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic        i_proceed, d_proceed, d_wr_stall, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic        i_data_valid, d_data_valid, route_err;

    mem_arbiter #(.MEM_LATENCY(MEM_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .d_miss(d_miss), .i_busy(i_busy), .d_busy(d_busy),
        .i_mem_en(i_mem_en), .d_mem_en(d_mem_en), .i_addr(i_addr), .d_addr(d_addr),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .memory_data_valid(memory_data_valid),
        .i_proceed(i_proceed), .d_proceed(d_proceed), .d_wr_stall(d_wr_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid), .route_err(route_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Memory model and per-cycle observation logs
    bit          mem_ret  [LOG_N];
    bit          ddv_log  [LOG_N];
    bit          idv_log  [LOG_N];
    logic [15:0] addr_log [LOG_N];
    bit          force_mdv = 1'b0;

    // Reference model: who holds memory, which reads belong to whom
    int   m_grant    = 0;   // 0 none, 1 I, 2 D
    int   m_last     = 1;
    bit   m_started  = 1'b0;
    bit   m_err      = 1'b0;
    bit   m_valid    = 1'b0;
    int   m_rst_cyc  = -1;
    int   iss [LOG_N];      // owner of the read issued in each cycle (0 = none)

    logic        e_ip, e_dp, e_en, e_wr, e_stall, e_idv, e_ddv, e_unmatched, e_busy, e_miss;
    logic [15:0] e_addr, e_data;
    int          e_src;

    always @(negedge clk) begin
        e_ip = (m_grant == 1);
        e_dp = (m_grant == 2);
        e_en = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_data = 16'h0;
        if (m_grant == 0) begin
            if (d_wr_en && !i_miss && !d_miss) begin
                e_en = 1'b1; e_wr = 1'b1; e_addr = d_wr_addr; e_data = d_wr_data;
            end
        end else if (m_grant == 1) begin
            e_en = i_mem_en; e_addr = i_addr;
        end else begin
            e_en = d_mem_en; e_addr = d_addr;
        end
        e_stall = d_wr_en && !e_wr;

        // A return belongs to whatever read was issued MEM_LATENCY cycles ago, unless reset intervened
        e_src = cyc - MEM_LATENCY;
        e_idv = 1'b0; e_ddv = 1'b0; e_unmatched = 1'b0;
        if (memory_data_valid) begin
            if (e_src > m_rst_cyc && iss[e_src] == 1)      e_idv = 1'b1;
            else if (e_src > m_rst_cyc && iss[e_src] == 2) e_ddv = 1'b1;
            else                                           e_unmatched = 1'b1;
        end

        if (m_valid) begin
            check("i_proceed",    i_proceed,    e_ip);
            check("d_proceed",    d_proceed,    e_dp);
            check("mem_en",       mem_en,       e_en);
            check("mem_wr",       mem_wr,       e_wr);
            check("mem_addr",     mem_addr,     e_addr);
            check("mem_data_in",  mem_data_in,  e_data);
            check("d_wr_stall",   d_wr_stall,   e_stall);
            check("i_data_valid", i_data_valid, e_idv);
            check("d_data_valid", d_data_valid, e_ddv);
            check("route_err",    route_err,    m_err);
        end

        if (cyc < LOG_N) begin
            iss[cyc]      = (e_en && !e_wr) ? m_grant : 0;
            ddv_log[cyc]  = (d_data_valid === 1'b1);
            idv_log[cyc]  = (i_data_valid === 1'b1);
            addr_log[cyc] = mem_addr;
        end
        if (mem_en === 1'b1 && mem_wr === 1'b0 && cyc + MEM_LATENCY < LOG_N)
            mem_ret[cyc + MEM_LATENCY] = 1'b1;

        if (rst) begin
            m_grant = 0; m_started = 1'b0; m_last = 1; m_err = 1'b0;
            m_rst_cyc = cyc; m_valid = 1'b1;
        end else if (m_valid) begin
            if (e_unmatched) m_err = 1'b1;
            if (m_grant == 0) begin
                if (i_miss && d_miss) m_grant = (m_last == 1) ? 2 : 1;
                else if (d_miss)      m_grant = 2;
                else if (i_miss)      m_grant = 1;
            end else begin
                e_busy = (m_grant == 1) ? i_busy : d_busy;
                e_miss = (m_grant == 1) ? i_miss : d_miss;
                if ((m_started && !e_busy) || (!m_started && !e_miss)) begin
                    m_last = m_grant; m_grant = 0; m_started = 1'b0;
                end else if (e_busy) begin
                    m_started = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        memory_data_valid = (cyc < LOG_N && mem_ret[cyc]) || force_mdv;
    endtask

    // One fill FSM: wait for grant, issue n reads, optionally wait for returns, then release
    task automatic fill(input bit is_d, input logic [15:0] base, input int n, input bit drain,
                        output int t0);
        int budget = 20;
        if (is_d) d_miss = 1'b1; else i_miss = 1'b1;
        #1;
        t0 = cyc;
        while (!(is_d ? d_proceed : i_proceed)) begin
            if (budget == 0) begin
                checks++; errors++;
                $display("FAIL grant_timeout: got no grant, expected grant within 20 cycles (cycle %0d)", cyc);
                return;
            end
            budget--;
            tick();
        end
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            if (is_d) begin d_busy = 1'b1; d_mem_en = 1'b1; d_addr = base + 16'(2 * k); end
            else      begin i_busy = 1'b1; i_mem_en = 1'b1; i_addr = base + 16'(2 * k); end
        end
        tick();
        if (is_d) d_mem_en = 1'b0; else i_mem_en = 1'b0;
        if (drain) repeat (MEM_LATENCY + 1) tick();
        if (is_d) begin d_busy = 1'b0; d_miss = 1'b0; end
        else      begin i_busy = 1'b0; i_miss = 1'b0; end
    endtask

    function automatic int count_log(input bit is_d, input int from, input int to);
        int s = 0;
        for (int c = from; c <= to; c++) s += is_d ? int'(ddv_log[c]) : int'(idv_log[c]);
        return s;
    endfunction

    initial begin
        int t0, t1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_mem_en",    mem_en,    16'h0);
        check("reset_mem_addr",  mem_addr,  16'h0);
        check("reset_proceed",   {i_proceed, d_proceed}, 16'h0);
        check("reset_route_err", route_err, 16'h0);

        // Tie after reset: D first; re-raised tie with last=D: I first
        i_miss = 1'b1; d_miss = 1'b1;
        tick();
        check("tie1_d_first", {i_proceed, d_proceed}, 16'h1);
        fill(1'b1, 16'h0200, 2, 1'b1, t0);
        d_miss = 1'b1;
        tick();
        check("tie_idle_gap", {i_proceed, d_proceed}, 16'h0);
        tick();
        check("tie2_i_first", {i_proceed, d_proceed}, 16'h2);
        fill(1'b0, 16'h0300, 2, 1'b1, t0);
        tick(); tick();
        check("pending_d_granted", d_proceed, 16'h1);
        fill(1'b1, 16'h0400, 1, 1'b1, t0);
        tick(); tick();

        // Single D fill of 8 words from 0x0010
        d_miss = 1'b1;
        tick();
        check("d_grant_next_cycle", d_proceed, 16'h1);
        fill(1'b1, 16'h0010, 8, 1'b1, t0);
        check("fill_first_addr", addr_log[t0],     16'h0010);
        check("fill_last_addr",  addr_log[t0 + 7], 16'h001E);
        check("fill_no_early_dv", 16'(ddv_log[t0 + MEM_LATENCY - 1]), 16'h0);
        check("fill_first_dv",    16'(ddv_log[t0 + MEM_LATENCY]),     16'h1);
        check("fill_d_dv_count",  16'(count_log(1'b1, t0, t0 + 20)), 16'd8);
        check("fill_i_dv_count",  16'(count_log(1'b0, t0, t0 + 20)), 16'd0);
        tick();

        // Store in IDLE goes straight out; same store during GRANT_I stalls
        tick();
        d_wr_en = 1'b1; d_wr_addr = 16'h1234; d_wr_data = 16'hBEEF;
        #1;
        check("store_mem_wr",   mem_wr,      16'h1);
        check("store_addr",     mem_addr,    16'h1234);
        check("store_data",     mem_data_in, 16'hBEEF);
        check("store_no_stall", d_wr_stall,  16'h0);
        tick();
        d_wr_en = 1'b0; i_miss = 1'b1;
        tick();
        d_wr_en = 1'b1;
        #1;
        check("store_stall_grant", d_wr_stall, 16'h1);
        check("store_no_wr_grant", mem_wr,     16'h0);
        tick();
        d_wr_en = 1'b0; i_miss = 1'b0;
        tick(); tick();

        // D released with reads in flight, I granted behind it
        d_miss = 1'b1;
        tick();
        fill(1'b1, 16'h0500, 8, 1'b0, t0);
        fill(1'b0, 16'h0600, 4, 1'b1, t1);
        check("inflight_d_dv", 16'(count_log(1'b1, t0 + 8, t0 + 11)), 16'd4);
        check("inflight_i_dv", 16'(count_log(1'b0, t0 + 8, t0 + 11)), 16'd0);
        check("i_fill_i_dv",   16'(count_log(1'b0, t1 + 4, t1 + 7)),  16'd4);
        check("i_fill_d_dv",   16'(count_log(1'b1, t1 + 4, t1 + 7)),  16'd0);
        tick(); tick();

        // Spurious return with an empty pipeline
        repeat (6) tick();
        force_mdv = 1'b1; memory_data_valid = 1'b1;
        #1;
        check("spurious_no_route", {i_data_valid, d_data_valid}, 16'h0);
        tick();
        force_mdv = 1'b0; memory_data_valid = 1'b0;
        check("route_err_set", route_err, 16'h1);
        repeat (3) tick();
        check("route_err_sticky", route_err, 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("route_err_cleared", route_err, 16'h0);

        // Reset in the middle of a D fill
        d_miss = 1'b1;
        tick();
        d_busy = 1'b1; d_mem_en = 1'b1; d_addr = 16'h0700;
        tick();
        d_addr = 16'h0702;
        tick();
        d_addr = 16'h0704; rst = 1'b1;
        tick();
        rst = 1'b0; d_miss = 1'b0; d_busy = 1'b0; d_mem_en = 1'b0;
        #1;
        check("midfill_rst_proceed", d_proceed, 16'h0);
        check("midfill_rst_mem_en",  mem_en,    16'h0);
        check("midfill_rst_addr",    mem_addr,  16'h0);
        repeat (5) tick();
        check("late_return_err", route_err, 16'h1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, 4, main-memory read latency in cycles (mem_en to memory_data_valid).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_miss, d_miss  in  1 each  miss_detected from the I-cache and D-cache fill FSMs.
REQ-005 i_busy, d_busy  in  1 each  fsm_busy from each fill FSM.
REQ-006 i_mem_en, d_mem_en  in  1 each  read enable from each fill FSM.
REQ-007 i_addr, d_addr  in  16 each  main_memory_address from each fill FSM.
REQ-008 d_wr_en  in  1; d_wr_addr  in  16; d_wr_data  in  16  write-through store request.
REQ-009 memory_data_valid  in  1  read-data valid from main memory.
REQ-010 i_proceed, d_proceed  out  1 each  grant to each fill FSM.
REQ-011 d_wr_stall  out  1  store not accepted this cycle.
REQ-012 mem_en  out  1; mem_wr  out  1; mem_addr  out  16; mem_data_in  out  16  memory command port.
REQ-013 i_data_valid, d_data_valid  out  1 each  memory_data_valid routed to the owning FSM.
REQ-014 route_err  out  1  sticky: valid returned with no matching outstanding read.

Function
REQ-015 FSM states IDLE, GRANT_I, GRANT_D, held in a registered state variable.
REQ-016 i_proceed = (state==GRANT_I); d_proceed = (state==GRANT_D); combinational from state only.
REQ-017 IDLE: d_miss only -> GRANT_D; i_miss only -> GRANT_I; both -> grant the cache not granted last (last_grant register, reset value I, so D wins first tie).
REQ-018 IDLE with no miss and d_wr_en: mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_stall=0, same cycle.
REQ-019 d_wr_en in IDLE with any miss pending, or in any GRANT state: d_wr_stall=1, nothing issued; misses take priority over stores.
REQ-020 GRANT_x: mem_en=x_mem_en, mem_wr=0, mem_addr=x_addr, mem_data_in=0; the other FSM's mem_en/addr ignored.
REQ-021 started flag set on first cycle GRANT_x sees x_busy=1; cleared on leaving GRANT.
REQ-022 GRANT_x -> IDLE when (started and x_busy==0) or (not started and x_miss==0); last_grant<=x on that transition.
REQ-023 No direct GRANT_I<->GRANT_D transition; minimum one IDLE cycle between grants.
REQ-024 Owner pipeline: MEM_LATENCY-deep shift register of {valid, owner}; entry pushed every cycle, valid=(mem_en & ~mem_wr), owner=current grant.
REQ-025 memory_data_valid with tail valid: assert i_data_valid or d_data_valid per tail owner, combinationally.
REQ-026 memory_data_valid with tail invalid: neither routed; route_err<=1 and stays set until reset.
REQ-027 Reads still in flight after release to IDLE are routed to the original owner; a new grant may start while previous returns drain.
REQ-028 Outputs idle value: mem_en=0, mem_wr=0, mem_addr=0, mem_data_in=0, all valids/proceeds 0.

Reset
REQ-029 rst: state=IDLE, started=0, last_grant=I, owner pipeline all invalid, route_err=0; all outputs at idle value the cycle after rst.
REQ-030 rst mid-fill drops the grant immediately; in-flight returns after reset are flagged per REQ-026.

Structure
REQ-031 State enum and owner encoding (OWNER_I=0, OWNER_D=1) in shared package cache_pkg.
REQ-032 Owner pipeline as sub-module owner_tag_pipe (parameter DEPTH=MEM_LATENCY).
REQ-033 Implementation 120-400 lines RTL; no latches; single clock domain.

Verification
REQ-034 d_miss=1 at cycle 0, D FSM fills 8 words from 0x0010 -> d_proceed=1 cycle 1; mem_addr 0x0010..0x001E; 8 d_data_valid pulses beginning 4 cycles after first mem_en; i_data_valid never high.
REQ-035 i_miss and d_miss both 1 at cycle 0 -> D granted first; after d_busy falls, one IDLE cycle, then i_proceed=1; next tie -> I granted first.
REQ-036 d_wr_en, addr 0x1234, data 0xBEEF in IDLE, no miss -> mem_wr=1, mem_addr=0x1234, mem_data_in=0xBEEF same cycle, d_wr_stall=0; same store during GRANT_I -> d_wr_stall=1, mem_wr=0.
REQ-037 D fill released while last 4 reads in flight, I miss granted immediately -> those 4 returns raise d_data_valid only; I returns raise i_data_valid only.
REQ-038 memory_data_valid forced high with empty pipeline -> no routed valid, route_err=1 until rst.
REQ-039 rst asserted mid-GRANT_D -> next cycle state IDLE, d_proceed=0, all outputs idle; late returns set route_err.
